// File: rtl/imem_if.sv
// Instruction-memory bus: single-outstanding req/ack read channel.
// Handshake: the master raises imem_req with imem_addr and holds both steady
// until the slave returns imem_ack with imem_rdata in the same cycle; the
// request completes on that edge and is never withdrawn before its ack.
interface imem_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential word reads, feeds the IF/ID
// register, parks one instruction across a stall and discards in-flight
// data on a redirect.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    imem_if.master      imem,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] if_id_pc,
    output logic [15:0] if_id_instr,
    output logic        if_id_valid,
    output logic [1:0]  dbg_state
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        req_q, req_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] pend_q, pend_d;         // redirect target waiting for the in-flight ack
    logic [15:0] hold_pc_q, hold_pc_d;   // one-entry buffer, full exactly while in HOLD
    logic [15:0] hold_instr_q, hold_instr_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    logic        load_new;
    logic [15:0] new_pc;
    logic [15:0] new_instr;

    // Fetch sequencing: next request address/state and the instruction ready for IF/ID
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        addr_d       = addr_q;
        pend_d       = pend_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        load_new     = 1'b0;
        new_pc       = addr_q;
        new_instr    = imem.imem_rdata;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                req_d   = 1'b1;
                addr_d  = redirect ? redirect_pc : RESET_PC;
            end
            ST_REQ: begin
                if (redirect && imem.imem_ack) begin
                    addr_d = redirect_pc;
                end else if (redirect) begin
                    pend_d  = redirect_pc;
                    state_d = ST_DROP;
                end else if (imem.imem_ack && !stall) begin
                    load_new = 1'b1;
                    addr_d   = addr_q + 16'd1;
                end else if (imem.imem_ack) begin
                    hold_pc_d    = addr_q;
                    hold_instr_d = imem.imem_rdata;
                    addr_d       = addr_q + 16'd1;
                    req_d        = 1'b0;
                    state_d      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    addr_d  = redirect_pc;
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end else if (!stall) begin
                    load_new  = 1'b1;
                    new_pc    = hold_pc_q;
                    new_instr = hold_instr_q;
                    req_d     = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            default: begin
                // Request stays up with the old address; only the target moves.
                if (redirect) pend_d = redirect_pc;
                if (imem.imem_ack) begin
                    addr_d  = redirect ? redirect_pc : pend_q;
                    state_d = ST_REQ;
                end
            end
        endcase
    end

    // IF/ID register: redirect flush beats stall hold beats load beats bubble
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (redirect) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!stall) begin
            if (load_new) begin
                pc_d    = new_pc;
                instr_d = new_instr;
                valid_d = 1'b1;
            end else begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset; a late ack in the reset cycle is ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            pend_q       <= RESET_PC;
            hold_pc_q    <= 16'h0000;
            hold_instr_q <= NOP_INSTR;
            pc_q         <= 16'h0000;
            instr_q      <= NOP_INSTR;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            pend_q       <= pend_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign if_id_pc       = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_valid    = valid_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural instruction memory with
// programmable wait states (rdata = addr ^ 16'hA5A5) and an expected queue
// of {pc, instr} pairs filled when the memory acks and drained when IF/ID loads.
module tb_fetch_unit;
    localparam logic [15:0] TB_RESET_PC = 16'hFFFE;
    localparam logic [15:0] TB_NOP      = 16'h0000;
    localparam logic [15:0] XOR_KEY     = 16'hA5A5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_instr;
    logic        if_id_valid;
    logic [1:0]  dbg_state;

    imem_if bus ();

    fetch_unit #(.RESET_PC(TB_RESET_PC), .NOP_INSTR(TB_NOP)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (bus.master),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid),
        .dbg_state   (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    int          check_count = 0;
    int          fail_count  = 0;
    logic [31:0] exp_q[$];
    logic [15:0] exp_addr;
    logic [15:0] pend;
    bit          dropping;
    bit          holding;
    int          ws;
    int          wait_cnt;
    int          valid_seen;

    task automatic check(input string tag, input logic [47:0] act, input logic [47:0] exp);
        check_count++;
        if (act !== exp) begin
            fail_count++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_addr = TB_RESET_PC;
        pend     = TB_RESET_PC;
        dropping = 1'b0;
        holding  = 1'b0;
        wait_cnt = 0;
    endtask

    // reset cycle, optionally with a late ack from a request the reset kills
    task automatic do_reset(input bit late_ack);
        reset          = 1'b1;
        stall          = 1'b0;
        redirect       = 1'b0;
        bus.imem_ack   = late_ack && bus.imem_req;
        bus.imem_rdata = 16'h1234;
        @(posedge clk); #1;
        check("rst_req",   bus.imem_req, 0);
        check("rst_addr",  bus.imem_addr, TB_RESET_PC);
        check("rst_pc",    if_id_pc, 0);
        check("rst_instr", if_id_instr, TB_NOP);
        check("rst_valid", if_id_valid, 0);
        check("rst_state", dbg_state, 0);
        reset        = 1'b0;
        bus.imem_ack = 1'b0;
        model_reset();
    endtask

    // drive one cycle: memory response, stall/redirect, then score IF/ID
    task automatic drive_cycle(input bit stl, input bit rdr, input logic [15:0] rpc);
        logic [31:0] prev;
        logic        prev_valid;
        bit          ack;
        bit          req_b;
        bit          load_exp;
        logic [31:0] e;
        prev       = {if_id_pc, if_id_instr};
        prev_valid = if_id_valid;
        req_b      = bus.imem_req;
        ack        = req_b && (wait_cnt >= ws);
        load_exp   = 1'b0;
        bus.imem_ack   = ack;
        bus.imem_rdata = ack ? (bus.imem_addr ^ XOR_KEY) : 16'hDEAD;
        stall       = stl;
        redirect    = rdr;
        redirect_pc = rpc;
        if (ack) begin
            check("fetch_addr", bus.imem_addr, exp_addr);
            if (rdr) begin
                exp_addr = rpc;
                dropping = 1'b0;
            end else if (dropping) begin
                exp_addr = pend;
                dropping = 1'b0;
            end else begin
                exp_q.push_back({exp_addr, exp_addr ^ XOR_KEY});
                exp_addr = exp_addr + 16'd1;
                holding  = stl;
                load_exp = !stl;
            end
        end else if (rdr) begin
            if (req_b) begin
                dropping = 1'b1;
                pend     = rpc;
            end else begin
                exp_addr = rpc;
                if (holding) begin
                    void'(exp_q.pop_back());
                    holding = 1'b0;
                end
            end
        end else if (holding && !stl) begin
            holding  = 1'b0;
            load_exp = 1'b1;
        end
        @(posedge clk); #1;
        if (ack) wait_cnt = 0;
        else if (req_b) wait_cnt++;
        if (if_id_valid) valid_seen++;
        if (rdr) begin
            check("redir_valid", if_id_valid, 0);
            check("redir_instr", if_id_instr, TB_NOP);
            check("redir_pc",    if_id_pc, prev[31:16]);
        end else if (stl) begin
            check("stall_hold", {if_id_valid, if_id_pc, if_id_instr}, {prev_valid, prev});
        end else if (load_exp) begin
            check("load_valid", if_id_valid, 1);
            if (exp_q.size() == 0) begin
                check("queue_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("ifid_data", {if_id_pc, if_id_instr}, e);
            end
        end else begin
            check("bubble", {if_id_valid, if_id_instr}, {1'b0, TB_NOP});
        end
        bus.imem_ack = 1'b0;
    endtask

    task automatic run_until_addr(input logic [15:0] target, input int limit);
        bit found;
        found = 1'b0;
        for (int i = 0; i < limit && !found; i++) begin
            if (bus.imem_req && bus.imem_addr == target) found = 1'b1;
            else drive_cycle(1'b0, 1'b0, 16'h0000);
        end
        check("reach_addr_timeout", found, 1);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        int v0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'h0000;
        ws = 0;
        model_reset();
        do_reset(1'b0);

        // first request one cycle after reset release, then wrap FFFE->0001
        drive_cycle(1'b0, 1'b0, 16'h0000);
        check("first_req",  bus.imem_req, 1);
        check("first_addr", bus.imem_addr, TB_RESET_PC);
        check("first_state", dbg_state, 1);
        run_until_addr(16'h0004, 20);

        // stall 3 cycles while pc=4 is acked: pc=3 held, pc=4 then pc=5
        drive_cycle(1'b1, 1'b0, 16'h0000);
        check("stall_state", dbg_state, 2);
        check("stall_pc3", if_id_pc, 16'h0003);
        check("stall_req_low", bus.imem_req, 0);
        drive_cycle(1'b1, 1'b0, 16'h0000);
        drive_cycle(1'b1, 1'b0, 16'h0000);
        drive_cycle(1'b0, 1'b0, 16'h0000);
        check("release_pc4", if_id_pc, 16'h0004);
        check("release_req", bus.imem_req, 1);
        drive_cycle(1'b0, 1'b0, 16'h0000);
        check("follow_pc5", {if_id_valid, if_id_pc}, {1'b1, 16'h0005});

        // redirect coinciding with the ack of pc=7
        run_until_addr(16'h0007, 10);
        drive_cycle(1'b0, 1'b1, 16'h0100);
        check("redir_addr", bus.imem_addr, 16'h0100);
        run_cycles(4);

        // two wait states: one instruction every three cycles
        ws = 2;
        v0 = valid_seen;
        run_cycles(12);
        check("ws2_rate", valid_seen - v0, 4);

        // double redirect during an outstanding request
        drive_cycle(1'b0, 1'b1, 16'h0200);
        check("drop_state", dbg_state, 3);
        drive_cycle(1'b0, 1'b1, 16'h0300);
        drive_cycle(1'b0, 1'b0, 16'h0000);
        check("drop_target", bus.imem_addr, 16'h0300);
        check("drop_done_state", dbg_state, 1);
        run_cycles(9);

        // reset in the middle of a request, with the ack landing in the reset cycle
        drive_cycle(1'b0, 1'b0, 16'h0000);
        do_reset(1'b1);
        ws = 0;
        run_cycles(6);
        check("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

    // global time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
